// File: rtl/arb_mux_if.sv
// Handshake bundle between an N-channel producer side and one consumer side,
// arbitrated by arb_mux. "slave" is the arbiter's view, "master" is the view
// of whatever drives the channels and consumes the output.
interface arb_mux_if #(
    parameter int NBITS   = 8,
    parameter int NINPUTS = 4
);
    localparam int SW = $clog2(NINPUTS);

    logic [NINPUTS-1:0]       in_val;
    logic [NINPUTS-1:0]       in_rdy;
    logic [NINPUTS*NBITS-1:0] in_msg;
    logic                     out_val;
    logic                     out_rdy;
    logic [NBITS-1:0]         out_msg;
    logic [SW-1:0]            out_sel;

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_sel
    );

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_sel
    );
endinterface

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage.
// Round-robin (RR=1) or fixed lowest-index priority (RR=0). The output
// register reloads in the same cycle it drains, so throughput is one
// message per cycle.
module arb_mux #(
    parameter int NBITS   = 8,
    parameter int NINPUTS = 4,
    parameter int RR      = 1
) (
    input logic      clk,
    input logic      reset_n,
    arb_mux_if.slave bus
);
    localparam int SW = $clog2(NINPUTS);

    logic [SW-1:0]      ptr_q;
    logic [SW-1:0]      grant;
    logic               any_val;
    logic               can_load;
    logic               in_xfer;
    logic [NINPUTS-1:0] in_rdy;

    logic               out_val_q, out_val_d;
    logic [NBITS-1:0]   out_msg_q, out_msg_d;
    logic [SW-1:0]      out_sel_q, out_sel_d;

    // Grant: first valid channel scanning upward from ptr with wrap-around.
    // With RR=0 ptr is tied to zero, which degenerates into lowest-index-wins.
    always_comb begin
        // NOTE: every variable written here gets a default before any branch,
        // otherwise the tool infers a latch to hold the old value.
        grant   = '0;
        any_val = 1'b0;
        for (int k = 0; k < NINPUTS; k++) begin
            int idx;
            // ptr < NINPUTS and k < NINPUTS, so one subtraction wraps the sum.
            idx = int'(ptr_q) + k;
            if (idx >= NINPUTS) idx = idx - NINPUTS;
            if (!any_val && bus.in_val[idx]) begin
                any_val = 1'b1;
                grant   = SW'(idx);
            end
        end
    end

    // Ready goes only to the granted channel, and only when the output slot
    // is free or draining this cycle. reset_n gates it so no channel sees a
    // handshake while the block is held in reset.
    always_comb begin
        can_load = ~out_val_q | bus.out_rdy;
        in_xfer  = can_load & any_val & reset_n;
        in_rdy   = '0;
        if (in_xfer) in_rdy[grant] = 1'b1;
    end

    // Output register next state: load on an input transfer, drop valid on a
    // bare output transfer, otherwise hold.
    always_comb begin
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        out_sel_d = out_sel_q;
        if (in_xfer) begin
            out_val_d = 1'b1;
            out_msg_d = bus.in_msg[int'(grant)*NBITS +: NBITS];
            out_sel_d = grant;
        end else if (out_val_q && bus.out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its inputs from before the edge.
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            out_sel_q <= '0;
        end else begin
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
            out_sel_q <= out_sel_d;
        end
    end

    if (RR != 0) begin : g_rr
        logic [SW-1:0] ptr_d;

        // Pointer advances past the winner on each input transfer; the
        // explicit wrap keeps it below NINPUTS for non-power-of-two counts.
        always_comb begin
            ptr_d = ptr_q;
            if (in_xfer) begin
                ptr_d = (int'(grant) == NINPUTS - 1) ? '0 : grant + SW'(1);
            end
        end

        // Round-robin pointer state.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) ptr_q <= '0;
            else          ptr_q <= ptr_d;
        end
    end else begin : g_fp
        assign ptr_q = '0;
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.out_val = out_val_q;
    assign bus.out_msg = out_msg_q;
    assign bus.out_sel = out_sel_q;
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter NBITS, default 8, bit width of each message.
REQ-002 SHALL have parameter NINPUTS, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_val  input  NINPUTS  per-channel valid.
REQ-007 SHALL have port in_rdy  output  NINPUTS  per-channel ready; at most one bit high per cycle.
REQ-008 SHALL have port in_msg  input  NINPUTS*NBITS  channel i occupies bits [i*NBITS +: NBITS].
REQ-009 SHALL have port out_val  output  1  output register holds a valid message.
REQ-010 SHALL have port out_rdy  input  1  downstream ready.
REQ-011 SHALL have port out_msg  output  NBITS  registered message.
REQ-012 SHALL have port out_sel  output  $clog2(NINPUTS)  index of the channel that supplied out_msg.

Function
REQ-013 SHALL contain one output register (out_val, out_msg, out_sel) and, when RR=1, a priority pointer ptr of $clog2(NINPUTS) bits.
REQ-014 SHALL define a transfer on input i as in_val[i] & in_rdy[i] at a rising edge; output transfer as out_val & out_rdy.
REQ-015 SHALL compute can_load = ~out_val | out_rdy (combinational, same cycle).
REQ-016 SHALL, when can_load=1 and at least one in_val bit is high, assert in_rdy only for the granted channel g; otherwise in_rdy = 0.
REQ-017 SHALL choose g with RR=0 as the lowest index i with in_val[i]=1.
REQ-018 SHALL choose g with RR=1 as the first i with in_val[i]=1 scanning ptr, ptr+1, ... NINPUTS-1, 0, ... ptr-1 (wrap-around).
REQ-019 SHALL make in_rdy independent of in_msg; in_rdy may depend on in_val, out_val, out_rdy, ptr.
REQ-020 SHALL, on an input transfer, load out_msg <= in_msg[g], out_sel <= g, out_val <= 1 at that edge; latency input-to-output exactly one cycle.
REQ-021 SHALL, on an output transfer with no simultaneous input transfer, clear out_val at that edge; out_msg/out_sel then hold last value.
REQ-022 SHALL, on simultaneous output and input transfer, replace the register contents (out_val stays 1); full throughput of one message per cycle.
REQ-023 SHALL hold out_val/out_msg/out_sel stable while out_val=1 and out_rdy=0.
REQ-024 SHALL, with RR=1, update ptr <= (g+1) mod NINPUTS only on an input transfer; ptr unchanged otherwise, including when g=NINPUTS-1 (wraps to 0).
REQ-025 SHALL, with RR=0, have no ptr state; behaviour otherwise identical.
REQ-026 SHALL never lose or duplicate a message: every input transfer produces exactly one output transfer, in input-transfer order.
REQ-027 SHALL treat NINPUTS not a power of two correctly: ptr never holds a value >= NINPUTS.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force out_val=0, out_msg=0, out_sel=0, ptr=0, and hence in_rdy=0.
REQ-029 SHALL, when reset asserts mid-operation, discard the held message; no transfer occurs on any edge with reset_n=0.
REQ-030 SHALL resume arbitration on the first rising edge after reset_n deasserts, with ptr=0.

Verification
REQ-031 SHALL cover: after reset, NINPUTS=4 RR=1, in_val=4'b1111, out_rdy=1 constantly -> out_sel sequence 0,1,2,3,0,... one per cycle, out_val=1 from cycle 1 on.
REQ-032 SHALL cover: RR=0, in_val=4'b1010 held, out_rdy=1 -> out_sel=1 every cycle; channel 3 starved; in_rdy=4'b0010.
REQ-033 SHALL cover: out_val=1, out_rdy=0 for 5 cycles with in_val=4'b0001 -> in_rdy=0, out_msg/out_sel stable; out_rdy=1 -> next cycle out_msg = in_msg[0] with in_val unchanged.
REQ-034 SHALL cover: ptr=3 (after grant to 2), in_val=4'b0001 -> g=0, then ptr=1; in_val=4'b1000 only -> g=3, ptr wraps to 0.
REQ-035 SHALL cover: reset_n pulsed low mid-stream with out_val=1 -> out_val=0, out_sel=0 immediately (before next edge); first post-reset grant with in_val=4'b1111 is channel 0.
REQ-036 SHALL cover: NINPUTS=3, NBITS=16, random in_val/out_rdy for 10k cycles -> scoreboard shows no loss, duplication, or reorder; ptr always < 3.
